// File: rtl/rename_regfile.sv
// rename_regfile
// Architectural register file with per-register rename (busy/tag) tracking.
// Issue reads source operands (or their pending ROB tag) and renames its
// destination; commit writes retired values and clears a rename only when
// the committing tag is still the current owner of the register.
//
// Input semantics: there is no valid/ready handshake. iss_valid, cmt_valid
// and flush are single-cycle strobes consumed at the rising edge on which
// rdy is high. When rdy is low they are ignored and no state changes.

module rename_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int TAG_W = 4,
  parameter int NRD   = 2,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [NRD*AW-1:0]    rs_addr,
  output logic [NRD-1:0]       rs_ready,
  output logic [NRD*XLEN-1:0]  rs_val,
  output logic [NRD*TAG_W-1:0] rs_tag,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [TAG_W-1:0]     iss_tag,
  input  logic                 cmt_valid,
  input  logic [AW-1:0]        cmt_rd,
  input  logic [XLEN-1:0]      cmt_val,
  input  logic [TAG_W-1:0]     cmt_tag,
  output logic [CNT_W-1:0]     busy_cnt
);

  // Per-register state. Entry 0 is never written, so it stays zero/not busy.
  logic [NREG-1:0][XLEN-1:0]  value_q;
  logic [NREG-1:0]            busy_q;
  logic [NREG-1:0][TAG_W-1:0] tag_q;

  // Decoded update strobes.
  logic             iss_eff;   // issue that actually renames its destination
  logic             iss_inc;   // issue that turns a free register busy
  logic             cmt_wr;    // commit that writes a value
  logic             cmt_clr;   // commit that releases the rename
  logic [CNT_W-1:0] cnt_nxt;

  // Classify this cycle's issue/commit; issue owns busy/tag on a collision.
  always_comb begin
    iss_eff = iss_valid && (iss_rd != '0) && !flush;
    iss_inc = iss_eff && !busy_q[iss_rd];
    cmt_wr  = cmt_valid && (cmt_rd != '0);
    cmt_clr = cmt_wr && busy_q[cmt_rd] && (tag_q[cmt_rd] == cmt_tag) &&
              !(iss_eff && (iss_rd == cmt_rd));
  end

  // Busy count moves by at most one per cycle; a flush empties it.
  always_comb begin
    cnt_nxt = busy_cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = busy_cnt + CNT_W'(iss_inc) - CNT_W'(cmt_clr);
    end
  end

  // Register state update; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q  <= '0;
      busy_q   <= '0;
      tag_q    <= '0;
      busy_cnt <= '0;
    end else if (rdy) begin
      if (cmt_wr) begin
        value_q[cmt_rd] <= cmt_val;
      end
      if (flush) begin
        busy_q <= '0;
        tag_q  <= '0;
      end else begin
        if (cmt_clr) begin
          busy_q[cmt_rd] <= 1'b0;
        end
        if (iss_eff) begin
          busy_q[iss_rd] <= 1'b1;
          tag_q[iss_rd]  <= iss_tag;
        end
      end
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports: stored value when free, commit bypass when the owning tag
  // retires this cycle, otherwise the pending tag.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             p_ready;
    logic [XLEN-1:0]  p_val;
    logic [TAG_W-1:0] p_tag;
    logic             byp;

    assign addr = rs_addr[k*AW +: AW];

    // Resolve one source operand.
    always_comb begin
      byp     = cmt_valid && rdy && (cmt_rd == addr) && (cmt_tag == tag_q[addr]);
      p_ready = 1'b1;
      p_val   = value_q[addr];
      p_tag   = '0;
      if (addr == '0) begin
        p_val = '0;
      end else if (!busy_q[addr]) begin
        p_val = value_q[addr];
      end else if (byp) begin
        p_val = cmt_val;
      end else begin
        p_ready = 1'b0;
        p_val   = '0;
        p_tag   = tag_q[addr];
      end
    end

    assign rs_ready[k]                = p_ready;
    assign rs_val[k*XLEN +: XLEN]     = p_val;
    assign rs_tag[k*TAG_W +: TAG_W]   = p_tag;
  end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with per-register rename tracking for the out-of-order core. Sits between decode/issue and the ROB. Issue reads source operands or their pending ROB tags and renames the destination. Commit writes retired values and clears renames whose tag still matches. Supports N read ports, same-cycle commit-to-read bypass, correct issue/commit collision on one register, and a global flush for misprediction recovery.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count; power of two, ≥2; register 0 hardwired to zero
- AW, 5, register address width, equal to log2(NREG)
- TAG_W, 4, ROB tag width
- NRD, 2, number of read ports
- CNT_W, 6, width of busy_cnt; holds 0..NREG
---
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low freezes all state
- flush  in  1  clear all renames
- rs_addr  in  NRD*AW  packed source addresses; port k is bits [k*AW +: AW]
- rs_ready  out  NRD  value is valid for port k
- rs_val  out  NRD*XLEN  operand value; zero when not ready
- rs_tag  out  NRD*TAG_W  pending ROB tag; zero when ready
- iss_valid  in  1  rename the destination this cycle
- iss_rd  in  AW  destination register
- iss_tag  in  TAG_W  ROB tag assigned to the destination
- cmt_valid  in  1  commit this cycle
- cmt_rd  in  AW  commit destination
- cmt_val  in  XLEN  commit value
- cmt_tag  in  TAG_W  ROB tag of the committing entry
- busy_cnt  out  CNT_W  registered count of renamed registers

## Operation
- State per register: value[XLEN], busy, tag[TAG_W]. Register 0 is never busy, its value is always 0, and all writes to it are dropped.
- Read port k, combinational:
  - If addr is 0 or busy=0: ready=1, val=value, tag=0.
  - Else, if cmt_valid && rdy && cmt_rd==addr && cmt_tag==tag (bypass): ready=1, val=cmt_val, tag=0.
  - Else: ready=0, val=0, tag=stored tag.
- Reads never reflect a same-cycle issue. Sources are read before their own instruction's destination is renamed.
- Commit, when cmt_valid and cmt_rd≠0:
  - value[cmt_rd] <= cmt_val, always.
  - busy is cleared only if busy && tag==cmt_tag, and no same-cycle issue targets the same register.
- Issue, when iss_valid, iss_rd≠0 and flush=0: busy<=1 and tag<=iss_tag. Issue wins the busy/tag update over a same-cycle commit to the same register. The commit value is still written.
- Flush: all busy<=0 and tags<=0 at the edge. A same-cycle commit still writes its value. A same-cycle issue is ignored.
- busy_cnt equals the number of busy registers after the edge. It is maintained incrementally (+1, −1 or unchanged per cycle) and is 0 after flush. Re-renaming an already-busy register does not change the count.
- rdy=0: no state changes; read outputs still valid, but the bypass is disabled.

## Timing
- Asynchronous reset (rst=0): all values 0, busy 0, tags 0, busy_cnt 0. Outputs immediately show ready=1, val=0, tag=0 on all ports.
- A write (issue, commit or flush) becomes visible to reads the cycle after its edge. A commit is also visible in the same cycle via the bypass.
- Reset asserted mid-operation clears all state without waiting for clk. State stays at reset until the first edge after release.
- No handshakes: every valid input is consumed in the cycle it is presented with rdy=1.

## Test plan
- Reset then read: after rst release, read x5 and x0 -> both ready=1, val=0, tag=0; busy_cnt=0.
- Rename, bypass, retire:
  - Issue rd=3, tag=7. Next cycle, read x3 -> ready=0, tag=7; busy_cnt=1.
  - Commit rd=3, tag=7, val=0xDEADBEEF in the same cycle as a read of x3 -> ready=1, val=0xDEADBEEF.
  - Following cycle -> busy=0, val=0xDEADBEEF; busy_cnt=0.
- Stale commit: issue rd=4 tag=2, then issue rd=4 tag=9, then commit rd=4 tag=2 val=0x11 -> x4 stays busy with tag=9, value=0x11, bypass not taken. Then commit tag=9 val=0x22 -> ready, val=0x22.
- Collision: x6 busy with tag=1; same cycle: commit rd=6 tag=1 val=0x55 and issue rd=6 tag=3 -> next cycle value=0x55, busy=1, tag=3, busy_cnt unchanged.
- Flush: rename x1, x2 and x7 (busy_cnt=3), then flush with a same-cycle commit rd=2 val=0x99 and issue rd=8 -> all ready, x2=0x99, x8 not busy, busy_cnt=0.
- x0 and rdy:
  - Issue/commit to rd=0 -> x0 reads 0, ready, busy_cnt unchanged.
  - With rdy=0, issue rd=5 -> no change.
  - Assert rst low mid-sequence -> all state clears immediately.
